// File: rtl/matrix_pkg.sv
// Shared types, widths and helpers for the determinant ALU operand packer.
// Element counts and size checks live here so the FSM and bench agree.
package matrix_pkg;

  localparam int ELEM_W = 8;
  localparam int MAX_N  = 5;
  localparam int FLAT_W = ELEM_W * MAX_N * MAX_N;
  localparam int IDX_W  = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_WAIT   = ST_WAIT,
    S_RESULT = ST_RESULT
  } state_e;

  function automatic logic [IDX_W-1:0] elem_count(input logic [2:0] n);
    logic [IDX_W-1:0] w;
    w = {2'b00, n};
    return w * w;
  endfunction

  function automatic logic size_legal(input logic [2:0] n);
    return (n >= 3'd2) && (32'(n) <= MAX_N);
  endfunction

endpackage

// File: rtl/matrix_flat_writer.sv
// A_flat operand register: synchronous clear plus one indexed byte write.
// Clear and write in the same cycle leave only the written byte set.
module matrix_flat_writer
  import matrix_pkg::*;
#(
  parameter int FW = FLAT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       data,
  output logic [FW-1:0]    flat
);

  logic [FW-1:0] flat_q;
  logic [FW-1:0] flat_d;

  always_comb begin
    flat_d = flat_q;
    if (clr) flat_d = '0;
    if (we && (int'(idx) < FW / ELEM_W))
      flat_d[int'(idx)*ELEM_W +: ELEM_W] = data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) flat_q <= '0;
    else          flat_q <= flat_d;
  end

  assign flat = flat_q;

endmodule

// File: rtl/matrix_operand_packer.sv
// Streams signed bytes into A_flat, runs the determinant ALU once,
// and hands the captured result downstream over valid/ready.
module matrix_operand_packer
  import matrix_pkg::*;
#(
  parameter int MAX_N          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [2:0]                  matrix_size,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic [8*MAX_N*MAX_N-1:0]    A_flat,
  output logic [2:0]                  size_out,
  output logic                        alu_start,
  input  logic                        alu_done,
  input  logic [7:0]                  alu_number,
  input  logic                        alu_overflow,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [7:0]                  res_number,
  output logic                        res_overflow,
  output logic                        err_size,
  output logic                        err_timeout,
  output logic                        busy
);

  localparam int FW = 8 * MAX_N * MAX_N;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       size_q, size_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       resn_q, resn_d;
  logic             reso_q, reso_d;
  logic             esz_q, esz_d;
  logic             etm_q, etm_d;
  logic             rdy_q, rdy_d;

  logic             accept;
  logic             wr_clr;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  assign accept = in_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    resn_d  = resn_q;
    reso_d  = reso_q;
    esz_d   = 1'b0;
    etm_d   = 1'b0;
    wr_clr  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    unique case (state_q)
      S_IDLE: begin
        wr_idx = '0;
        if (accept) begin
          if (size_legal(matrix_size)) begin
            size_d  = matrix_size;
            wr_clr  = 1'b1;
            wr_en   = 1'b1;
            idx_d   = IDX_W'(1);
            state_d = S_LOAD;
          end else begin
            esz_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == elem_count(size_q) - IDX_W'(1))
            state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          resn_d  = alu_number;
          reso_d  = alu_overflow;
          state_d = S_RESULT;
        end else if (cnt_q == CNT_LAST) begin
          resn_d  = 8'd0;
          reso_d  = 1'b1;
          etm_d   = 1'b1;
          state_d = S_RESULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // ready is registered so it reads 0 while reset is held
    rdy_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      resn_q  <= '0;
      reso_q  <= 1'b0;
      esz_q   <= 1'b0;
      etm_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      resn_q  <= resn_d;
      reso_q  <= reso_d;
      esz_q   <= esz_d;
      etm_q   <= etm_d;
      rdy_q   <= rdy_d;
    end
  end

  matrix_flat_writer #(.FW(FW)) u_writer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (wr_clr),
    .we      (wr_en),
    .idx     (wr_idx),
    .data    (in_data),
    .flat    (A_flat)
  );

  assign in_ready     = rdy_q;
  assign size_out     = size_q;
  assign alu_start    = (state_q == S_START);
  assign res_valid    = (state_q == S_RESULT);
  assign res_number   = resn_q;
  assign res_overflow = reso_q;
  assign err_size     = esz_q;
  assign err_timeout  = etm_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_matrix_operand_packer.sv
// Directed bench for matrix_operand_packer: packing, ALU handshake,
// timeout, illegal sizes, result back-pressure and mid-op reset.
module tb_matrix_operand_packer;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   matrix_size = 3'd0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_ready;
  logic [199:0] A_flat;
  logic [2:0]   size_out;
  logic         alu_start;
  logic         alu_done = 1'b0;
  logic [7:0]   alu_number = 8'd0;
  logic         alu_overflow = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [7:0]   res_number;
  logic         res_overflow;
  logic         err_size;
  logic         err_timeout;
  logic         busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int start_cnt = 0;
  int esz_cnt = 0;
  int etm_cnt = 0;
  int beat_cnt = 0;
  logic [199:0] exp_flat;

  always #5 clock = ~clock;

  matrix_operand_packer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .matrix_size  (matrix_size),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .A_flat       (A_flat),
    .size_out     (size_out),
    .alu_start    (alu_start),
    .alu_done     (alu_done),
    .alu_number   (alu_number),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_number   (res_number),
    .res_overflow (res_overflow),
    .err_size     (err_size),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  always @(negedge clock) begin
    if (alu_start === 1'b1) start_cnt++;
    if (err_size === 1'b1) esz_cnt++;
    if (err_timeout === 1'b1) etm_cnt++;
    if (in_valid && in_ready === 1'b1) beat_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    alu_done = 1'b0;
    res_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [2:0] sz);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    matrix_size = sz;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    total_cnt++;
    if (n >= 100) $display("FAIL beat_wait: in_ready stuck at %b, required 1", in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1;
    matrix_size = 3'd2;
    alu_done = 1'b1;
    step();
    step();
    total_cnt++;
    if ({in_ready, busy, alu_start, res_valid, res_overflow, err_size, err_timeout} !== 7'd0)
      $display("FAIL reset_ctrl: got %b required 0000000",
               {in_ready, busy, alu_start, res_valid, res_overflow, err_size, err_timeout});
    else pass_cnt++;
    total_cnt++;
    if (A_flat !== 200'd0) $display("FAIL reset_flat: got %h required 0", A_flat);
    else pass_cnt++;
    total_cnt++;
    if ({size_out, res_number} !== 11'd0)
      $display("FAIL reset_regs: got %h required 0", {size_out, res_number});
    else pass_cnt++;
    in_valid = 1'b0;
    alu_done = 1'b0;
    do_reset();
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_reset: in_ready=%b busy=%b required 1 0", in_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_n2_basic();
    start_cnt = 0;
    send_beat(8'd3, 3'd2);
    send_beat(8'd1, 3'd2);
    send_beat(8'd2, 3'd2);
    send_beat(8'd4, 3'd2);
    total_cnt++;
    if (alu_start !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL n2_start_latency: alu_start=%b in_ready=%b required 1 0", alu_start, in_ready);
    else pass_cnt++;
    step();
    step();
    step();
    alu_number = 8'd10;
    alu_overflow = 1'b0;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    exp_flat = '0;
    exp_flat[31:0] = 32'h04020103;
    total_cnt++;
    if (A_flat !== exp_flat) $display("FAIL n2_flat: got %h required %h", A_flat, exp_flat);
    else pass_cnt++;
    total_cnt++;
    if (res_valid !== 1'b1 || res_number !== 8'd10 || res_overflow !== 1'b0)
      $display("FAIL n2_result: valid=%b num=%0d ovf=%b required 1 10 0",
               res_valid, res_number, res_overflow);
    else pass_cnt++;
    total_cnt++;
    if (start_cnt !== 1 || size_out !== 3'd2)
      $display("FAIL n2_start_once: starts=%0d size=%0d required 1 2", start_cnt, size_out);
    else pass_cnt++;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total_cnt++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL n2_handshake: valid=%b ready=%b busy=%b required 0 1 0",
               res_valid, in_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_n5_gaps();
    logic [7:0] v;
    int bad;
    start_cnt = 0;
    exp_flat = '0;
    for (int k = 0; k < 25; k++) begin
      v = 8'(k * 11 + 3);
      exp_flat[k*8 +: 8] = v;
      if (k == 24) begin
        total_cnt++;
        if (start_cnt !== 0) $display("FAIL n5_early_start: starts=%0d required 0", start_cnt);
        else pass_cnt++;
      end
      send_beat(v, (k == 0) ? 3'd5 : 3'd2);
      if (k < 24) repeat ($urandom_range(0, 2)) step();
    end
    total_cnt++;
    if (alu_start !== 1'b1) $display("FAIL n5_start: alu_start=%b required 1", alu_start);
    else pass_cnt++;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (in_ready !== 1'b0) bad++;
      step();
    end
    alu_number = 8'hF6;
    alu_overflow = 1'b1;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    if (in_ready !== 1'b0) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL n5_ready_low: %0d cycles with in_ready high, required 0", bad);
    else pass_cnt++;
    for (int k = 0; k < 25; k++) begin
      total_cnt++;
      if (A_flat[k*8 +: 8] !== exp_flat[k*8 +: 8])
        $display("FAIL n5_byte%0d: got %h required %h", k, A_flat[k*8 +: 8], exp_flat[k*8 +: 8]);
      else pass_cnt++;
    end
    total_cnt++;
    if (res_number !== 8'hF6 || res_overflow !== 1'b1 || size_out !== 3'd5)
      $display("FAIL n5_result: num=%h ovf=%b size=%0d required f6 1 5",
               res_number, res_overflow, size_out);
    else pass_cnt++;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_illegal_size();
    esz_cnt = 0;
    start_cnt = 0;
    send_beat(8'h77, 3'd6);
    total_cnt++;
    if (err_size !== 1'b1 || busy !== 1'b0)
      $display("FAIL size6_err: err_size=%b busy=%b required 1 0", err_size, busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (err_size !== 1'b0) $display("FAIL size_pulse_len: err_size=%b required 0", err_size);
    else pass_cnt++;
    send_beat(8'h66, 3'd1);
    step();
    step();
    total_cnt++;
    if (esz_cnt !== 2 || start_cnt !== 0 || busy !== 1'b0)
      $display("FAIL size_counts: errs=%0d starts=%0d busy=%b required 2 0 0",
               esz_cnt, start_cnt, busy);
    else pass_cnt++;
    total_cnt++;
    if (A_flat !== exp_flat) $display("FAIL flat_retained: got %h required %h", A_flat, exp_flat);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    etm_cnt = 0;
    exp_flat = '0;
    for (int k = 0; k < 9; k++) begin
      exp_flat[k*8 +: 8] = 8'(8'hF0 + k);
      send_beat(8'(8'hF0 + k), 3'd3);
    end
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total_cnt++;
    if (n != 65) $display("FAIL timeout_cycles: got %0d required 65", n);
    else pass_cnt++;
    total_cnt++;
    if (err_timeout !== 1'b1 || res_number !== 8'd0 || res_overflow !== 1'b1)
      $display("FAIL timeout_result: err=%b num=%0d ovf=%b required 1 0 1",
               err_timeout, res_number, res_overflow);
    else pass_cnt++;
    total_cnt++;
    if (A_flat !== exp_flat || size_out !== 3'd3)
      $display("FAIL timeout_hold: flat=%h size=%0d required %h 3", A_flat, size_out, exp_flat);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad;
    int b0;
    b0 = beat_cnt;
    bad = 0;
    in_valid = 1'b1;
    in_data = 8'h55;
    matrix_size = 3'd2;
    for (int c = 0; c < 10; c++) begin
      step();
      if (res_valid !== 1'b1 || res_number !== 8'd0 || res_overflow !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    total_cnt++;
    if (bad != 0 || beat_cnt != b0)
      $display("FAIL bp_hold: bad=%0d beats=%0d required 0 0", bad, beat_cnt - b0);
    else pass_cnt++;
    total_cnt++;
    if (etm_cnt !== 1) $display("FAIL timeout_pulse: pulses=%0d required 1", etm_cnt);
    else pass_cnt++;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total_cnt++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: valid=%b ready=%b required 0 1", res_valid, in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    exp_flat = '0;
    exp_flat[7:0] = 8'h55;
    total_cnt++;
    if (A_flat !== exp_flat || busy !== 1'b1)
      $display("FAIL bp_next_beat: flat=%h busy=%b required %h 1", A_flat, busy, exp_flat);
    else pass_cnt++;
    send_beat(8'h01, 3'd2);
    send_beat(8'h02, 3'd2);
    send_beat(8'h03, 3'd2);
    step();
    alu_number = 8'h2A;
    alu_overflow = 1'b0;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    total_cnt++;
    if (res_valid !== 1'b1 || res_number !== 8'h2A || A_flat[31:0] !== 32'h03020155)
      $display("FAIL bp_followup: valid=%b num=%h flat=%h required 1 2a 03020155",
               res_valid, res_number, A_flat[31:0]);
    else pass_cnt++;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int bad;
    send_beat(8'd9, 3'd2);
    send_beat(8'd8, 3'd2);
    send_beat(8'd7, 3'd2);
    send_beat(8'd6, 3'd2);
    step();
    step();
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, busy, alu_start, res_valid, res_overflow, err_size, err_timeout} !== 7'd0 ||
        A_flat !== 200'd0 || size_out !== 3'd0 || res_number !== 8'd0)
      $display("FAIL wait_reset_outs: ctrl=%b flat=%h size=%0d num=%0d required all 0",
               {in_ready, busy, alu_start, res_valid, res_overflow, err_size, err_timeout},
               A_flat, size_out, res_number);
    else pass_cnt++;
    step();
    alu_number = 8'h99;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    reset_n = 1'b1;
    start_cnt = 0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0 || start_cnt != 0)
      $display("FAIL wait_reset_quiet: bad=%0d starts=%0d required 0 0", bad, start_cnt);
    else pass_cnt++;
    send_beat(8'hFF, 3'd2);
    send_beat(8'hFE, 3'd2);
    send_beat(8'hFD, 3'd2);
    send_beat(8'hFC, 3'd2);
    step();
    alu_number = 8'h05;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    total_cnt++;
    if (res_valid !== 1'b1 || res_number !== 8'h05 || A_flat[31:0] !== 32'hFCFDFEFF || start_cnt != 1)
      $display("FAIL wait_reset_reload: valid=%b num=%h flat=%h starts=%0d required 1 05 fcfdfeff 1",
               res_valid, res_number, A_flat[31:0], start_cnt);
    else pass_cnt++;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_n2_basic();
    test_n5_gaps();
    test_illegal_size();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/matrix_operand_packer.md
Name: matrix_operand_packer

Overview:
- Producer end of the flat-matrix interface of the coprocessor's determinant ALU. It accepts signed 8-bit matrix elements as a byte stream (valid/ready) and packs them into the 200-bit A_flat operand.
- It pulses a start to the ALU, waits for done, captures number and overflow_flag, and presents the result downstream with a valid/ready handshake.
- It sits between the instruction/data path and the determinant ALU.

Parameters:
- MAX_N, 5, maximum matrix dimension. A_flat width is 8*MAX_N*MAX_N.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the packer aborts the ALU operation.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- matrix_size  in  3  dimension N. Sampled on the first accepted beat. Legal values are 2..5.
- in_valid  in  1  element beat valid.
- in_data  in  8  element value, signed two's complement, row-major order.
- in_ready  out  1  packer can accept a beat.
- A_flat  out  200  packed operand to the ALU.
- size_out  out  3  latched N to the ALU matrix_size.
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  ALU completion.
- alu_number  in  8  ALU result.
- alu_overflow  in  1  ALU overflow_flag.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_number  out  8  captured result.
- res_overflow  out  1  captured overflow.
- err_size  out  1  one-cycle pulse: illegal matrix_size.
- err_timeout  out  1  one-cycle pulse: ALU did not finish in time.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, while reset_n=0): state=IDLE. All outputs are 0 and all counters are 0. A_flat=0. size_out=0.
- Packing: element k = r*N + c occupies A_flat[8k+7:8k], packed densely with stride N (not MAX_N). For N=2, the elements occupy A_flat[31:0]. All bits above 8*N*N-1 are 0.
- FSM states: IDLE, LOAD, START, WAIT, RESULT.
- IDLE:
  - in_ready=1.
  - On an in_valid beat with matrix_size in 2..5: latch N into size_out, clear A_flat, write in_data to element 0, set idx=1, go to LOAD.
  - On an in_valid beat with an illegal size (0, 1, 6, 7): the beat is consumed and discarded, err_size pulses 1 cycle, state stays IDLE.
- LOAD:
  - in_ready=1.
  - Each beat writes element idx and increments idx.
  - The beat with idx = N*N-1 is the last: go to START.
  - No beat in a cycle: hold state.
  - matrix_size changes during LOAD are ignored.
- START:
  - in_ready=0. alu_start=1 for exactly this cycle. Go to WAIT and clear the timeout counter.
  - Latency from the last accepted beat to alu_start is 1 cycle.
- WAIT:
  - in_ready=0. A_flat and size_out are held stable.
  - alu_done=1: capture alu_number into res_number and alu_overflow into res_overflow, go to RESULT.
  - Counter reaching TIMEOUT_CYCLES without done: res_number=0, res_overflow=1, err_timeout pulses, go to RESULT.
  - alu_done is ignored in every state other than WAIT.
- RESULT:
  - res_valid=1. res_number and res_overflow are held until the handshake.
  - res_valid & res_ready: go to IDLE next cycle with res_valid=0. in_ready=1 from that next cycle.
  - The packer never accepts a new matrix while res_valid=1.
- A_flat keeps its value after returning to IDLE and is cleared on the first beat of the next matrix.
- Back-to-back throughput for N×N: N*N beats + 1 (START) + ALU latency + 1 (capture) + result handshake.
- Reset asserted mid-operation (any state): immediate return to IDLE. No alu_start or res_valid is emitted afterwards for the aborted matrix.

Decomposition:
- Shared package matrix_pkg:
  - ELEM_W=8, MAX_N=5, FLAT_W=200.
  - State encoding localparams for IDLE/LOAD/START/WAIT/RESULT.
  - Function elem_count(N)=N*N.
  - Function size_legal(N).
- One sub-module, matrix_flat_writer: the A_flat register with clear and indexed byte-write (idx, data, we, clr). The FSM stays in the top module.

Test Plan:
- N=2, stream 3,1,2,4, ALU model returns 10 after 3 cycles -> A_flat[31:0]=0x04020103 with upper bits 0. alu_start pulses once, 1 cycle after the 4th beat. res_valid with res_number=10, res_overflow=0.
- N=5, 25 beats with random in_valid gaps -> every byte lands at 8*(5r+c). alu_start fires only after beat 25. in_ready=0 from START until the result handshake completes.
- First beat with matrix_size=6, then 1 -> err_size pulses once per beat. State stays IDLE. busy=0. No alu_start.
- N=3 load, ALU never asserts done -> after 64 WAIT cycles, err_timeout pulses and res_valid=1 with res_number=0, res_overflow=1.
- Result back-pressure: res_ready held 0 for 10 cycles with in_valid=1 -> res_valid and data stable, in_ready=0, no beats consumed. res_ready=1 -> IDLE next cycle and the next beat is accepted.
- reset_n asserted during WAIT with alu_done arriving 1 cycle later -> all outputs 0, no res_valid, and a following N=2 load completes normally.
